serial_add_seq: RTL and testbench

//  Sequencer that performs a WIDTH-bit addition by time-sharing one 4-bit ripple adder

---
 rtl/serial_add_seq.sv | 131 +++++++++++++
 tb/tb_serial_add_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq: WIDTH-bit adder that reuses one 4-bit ripple slice over WIDTH/4 cycles.
// Nibbles are processed least significant first. The carry is held in a register between nibbles.
// Handshake: start is accepted in IDLE or DONE. busy is high in RUN. done pulses for one cycle.
// Optional feature macro: SERADD_SUB_EN adds a 'sub' port for A-B (two's complement via ~B + 1).
module serial_add_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERADD_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : gen_bad_width
    $error("serial_add_seq: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  opa_q, opb_q, s_q;
  logic              carry_q, cout_q, busy_q, done_q;
  logic [CntW-1:0]   cnt_q;

  logic [3:0]        a_nib, b_nib, sum_nib;
  logic [4:0]        chain;
  logic              slice_cout;
  logic [WIDTH-1:0]  opb_load;
  logic              carry_load;

  // Operand B and initial carry as latched on an accepted start.
  always_comb begin
    opb_load   = B;
    carry_load = Cin;
`ifdef SERADD_SUB_EN
    if (sub) begin
      opb_load   = ~B;
      carry_load = 1'b1;
    end
`endif
  end

  // Select the active nibble and run it through the 4-bit full-adder chain.
  always_comb begin
    a_nib   = '0;
    b_nib   = '0;
    sum_nib = '0;
    chain   = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CntW'(i)) begin
        a_nib = opa_q[4*i +: 4];
        b_nib = opb_q[4*i +: 4];
      end
    end
    chain[0] = carry_q;
    for (int j = 0; j < 4; j++) begin
      sum_nib[j]   = a_nib[j] ^ b_nib[j] ^ chain[j];
      chain[j+1]   = (a_nib[j] & b_nib[j]) | (chain[j] & (a_nib[j] ^ b_nib[j]));
    end
    slice_cout = chain[4];
  end

  // Control FSM with registered outputs; DONE accepts a new start like IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            opa_q   <= A;
            opb_q   <= opb_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          for (int i = 0; i < NIB; i++) begin
            if (cnt_q == CntW'(i)) s_q[4*i +: 4] <= sum_nib;
          end
          carry_q <= slice_cout;
          if (cnt_q == CntW'(NIB - 1)) begin
            cout_q  <= slice_cout;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: expected {Cout,S} pushed at issue, popped on done.
module tb_serial_add_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         Cin;
  logic [W-1:0] S;
  logic         Cout, busy, done;
`ifdef SERADD_SUB_EN
  logic         sub;
`endif

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  serial_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
`ifdef SERADD_SUB_EN
    .sub   (sub),
`endif
    .S     (S),
    .Cout  (Cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got S=%0h Cout=%0b expected no done", S, Cout);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({Cout, S} !== e) begin
          errors++;
          $display("FAIL result: got Cout=%0b S=%0h expected Cout=%0b S=%0h",
                   Cout, S, e[W], e[W-1:0]);
        end
      end
    end
  end

  // Drive a start on the next edge; caller is at a negedge with the DUT able to accept.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, input logic push, input logic [W:0] exp);
    A = a; B = b; Cin = c; start = 1'b1;
`ifdef SERADD_SUB_EN
    sub = s;
`else
    if (s) $display("note: sub requested without SERADD_SUB_EN");
`endif
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy=%0b done=%0b expected idle", busy, done);
    end
  endtask

  // Returns number of negedges until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done: got done=0 expected done within 50 cycles");
    end
  endtask

  initial begin
    int gap;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
`ifdef SERADD_SUB_EN
    sub = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    check("reset_S", 32'(S), 32'h0);
    check("reset_flags", {29'b0, Cout, busy, done}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: latency and busy profile
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, {1'b0, 16'h2233});
    for (int k = 0; k < 4; k++) begin
      check("t1_busy", {30'b0, busy, done}, 32'h2);
      @(negedge clk);
    end
    check("t1_done", {30'b0, busy, done}, 32'h1);
    @(negedge clk);
    check("t1_idle", {30'b0, busy, done}, 32'h0);
    check("t1_S_hold", 32'(S), 32'h2233);

    // Test 2: full carry ripple, carry-in only, all ones
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b1, 16'h0000});
    wait_idle();
    issue(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, {1'b0, 16'h0001});
    wait_idle();
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, {1'b1, 16'hFFFF});
    wait_idle();

    // Test 3: start in RUN is ignored; start in DONE chains back-to-back
    issue(16'h00F0, 16'h0F10, 1'b0, 1'b0, 1'b1, {1'b0, 16'h1000});
    A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(gap);
    issue(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1, {1'b1, 16'h0001});
    wait_done(gap);
    check("t3_gap", 32'(gap + 1), 32'd5);
    wait_idle();

    // Test 4: reset during nibble 2 aborts (no expectation pushed)
    issue(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_rst_S", 32'(S), 32'h0);
    check("t4_rst_flags", {29'b0, Cout, busy, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t4_no_done", {30'b0, busy, done}, 32'h0);
    issue(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1, {1'b0, 16'h0406});
    wait_idle();

    // Test 5: operand changes while busy have no effect
    issue(16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b1, {1'b0, 16'hBCDF});
    for (int k = 0; k < 4; k++) begin
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
      @(negedge clk);
    end
    wait_idle();

`ifdef SERADD_SUB_EN
    // Test 6: subtraction; Cout=1 means no borrow
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, {1'b0, 16'hFFFE});
    wait_idle();
    issue(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, {1'b1, 16'h0002});
    wait_idle();
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, {1'b0, 16'h2233});
    wait_idle();
`endif

    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
